// File: rtl/pp_pipeline_accel_fifo_rr_arb.sv
// Round-robin burst arbiter merging per-channel FWFT FIFOs into one
// tagged output stream behind a one-deep registered output stage.
module pp_pipeline_accel_fifo_rr_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 4,
    parameter int CH_WIDTH   = 2,
    parameter int BURST_LEN  = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_empty_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_dout,
    output logic [NUM_CH-1:0]            ch_read,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_WIDTH-1:0]          out_ch,
    output logic                         out_last,
    output logic                         busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CH_WIDTH-1:0]    rr_ptr;
    logic [CH_WIDTH-1:0]    gnt;
    logic [CH_WIDTH-1:0]    pick;
    logic                   any_req;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]   beat_nxt;
    logic                   slot_free;
    logic                   gnt_avail;
    logic                   pop;
    logic                   burst_end;
    logic                   release_gnt;
    logic                   take_grant;

    // Scan downward so the channel closest to rr_ptr is written last and wins.
    always_comb begin
        int                  idx;
        logic [CH_WIDTH-1:0] cand;
        pick    = '0;
        any_req = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx  = (int'(rr_ptr) + i) % NUM_CH;
            cand = CH_WIDTH'(idx);
            if (ch_empty_n[cand]) begin
                pick    = cand;
                any_req = 1'b1;
            end
        end
    end

    assign slot_free   = ~out_valid | out_ready;
    assign gnt_avail   = ch_empty_n[gnt];
    assign pop         = (state == GRANT) & gnt_avail & slot_free;
    assign beat_nxt    = beat_cnt + 1'b1;
    assign burst_end   = (beat_nxt == CNT_WIDTH'(BURST_LEN));
    assign release_gnt = (state == GRANT) & (~gnt_avail | (pop & burst_end));
    assign take_grant  = (state == IDLE) & enable & any_req;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take_grant)  state_nxt = GRANT;
            GRANT:   if (release_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ch_read = '0;
        if (pop) ch_read[gnt] = 1'b1;
        busy = (state == GRANT) | out_valid;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr   <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            if (take_grant) begin
                gnt      <= pick;
                beat_cnt <= '0;
            end else if (pop) begin
                beat_cnt <= beat_nxt;
            end
            if (release_gnt)
                rr_ptr <= (gnt == CH_WIDTH'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= ch_dout[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            out_ch    <= gnt;
            out_last  <= burst_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_rr_arb.sv
// Directed bench for the round-robin FIFO arbiter with a FIFO model
// and an expected-word scoreboard.
module tb_pp_pipeline_accel_fifo_rr_arb;

    localparam int NUM_CH = 4;
    localparam int DW     = 4;
    localparam int CHW    = 2;
    localparam int BL     = 2;
    localparam int CW     = 4;

    logic                 ap_clk     = 1'b0;
    logic                 ap_rst_n   = 1'b0;
    logic                 enable     = 1'b0;
    logic                 out_ready  = 1'b0;
    logic [NUM_CH-1:0]    ch_empty_n = '0;
    logic [NUM_CH*DW-1:0] ch_dout    = '0;
    logic [NUM_CH-1:0]    ch_read;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic [CHW-1:0]       out_ch;
    logic                 out_last;
    logic                 busy;

    pp_pipeline_accel_fifo_rr_arb #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_WIDTH(CHW),
        .BURST_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
        .ch_empty_n(ch_empty_n), .ch_dout(ch_dout), .ch_read(ch_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    logic [DW-1:0]      fq[NUM_CH][$];
    logic [CHW+DW:0]    exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int pushed   = 0;
    int accepted = 0;
    bit sb_on    = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic put(input int k, input logic [DW-1:0] d);
        fq[k].push_back(d);
        if (sb_on) pushed++;
    endtask

    task automatic exp_w(input int k, input logic last, input logic [DW-1:0] d);
        exp_q.push_back({CHW'(k), last, d});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        chk(tag, 32'(n < 100), 1);
    endtask

    // FIFO model: pop on the sampled strobe, then present the new head.
    always @(posedge ap_clk) begin
        logic [NUM_CH-1:0] rd;
        rd = ch_read;
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd[k] && fq[k].size() != 0) void'(fq[k].pop_front());
            ch_empty_n[k] = (fq[k].size() != 0);
            ch_dout[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : '0;
        end
    end

    always @(negedge ap_clk) begin
        logic [CHW+DW:0] e;
        if (ap_rst_n && sb_on && out_valid && out_ready) begin
            accepted++;
            chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_word", 32'({out_ch, out_last, out_data}), 32'(e));
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge ap_clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ch_read", 32'(ch_read), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;

        // single channel, partial second burst
        put(1, 4'hA); put(1, 4'hB); put(1, 4'hC);
        exp_w(1, 0, 4'hA); exp_w(1, 1, 4'hB); exp_w(1, 0, 4'hC);
        drain("single_drain");
        chk("single_rr", 32'(dut.rr_ptr), 2);

        // fairness from a clean pointer
        @(negedge ap_clk); ap_rst_n = 1'b0;
        @(negedge ap_clk); ap_rst_n = 1'b1;
        for (int k = 0; k < NUM_CH; k++)
            for (int j = 0; j < ((k == 0) ? 4 : 2); j++)
                put(k, DW'(k * 4 + j));
        for (int b = 0; b < 5; b++) begin
            exp_w(b % 4, 0, DW'((b % 4) * 4 + ((b == 4) ? 2 : 0)));
            exp_w(b % 4, 1, DW'((b % 4) * 4 + ((b == 4) ? 3 : 1)));
        end
        drain("fair_drain");
        chk("fair_rr", 32'(dut.rr_ptr), 1);

        // backpressure mid-burst
        put(2, 4'h5); put(2, 4'h6); put(2, 4'h7); put(2, 4'h8);
        exp_w(2, 0, 4'h5); exp_w(2, 1, 4'h6);
        exp_w(2, 0, 4'h7); exp_w(2, 1, 4'h8);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge ap_clk); n++; end
        chk("bp_start", 32'(out_valid), 1);
        @(posedge ap_clk); #1 out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 6);
            chk("bp_ch", 32'(out_ch), 2);
            chk("bp_last", 32'(out_last), 1);
            chk("bp_read", 32'(ch_read), 0);
        end
        @(posedge ap_clk); #1 out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_rr", 32'(dut.rr_ptr), 3);

        // pointer wrap: rr_ptr=3, ch0 and ch2 pending
        put(0, 4'h9); put(2, 4'hA);
        exp_w(0, 0, 4'h9); exp_w(2, 0, 4'hA);
        n = 0;
        while (!(out_valid && out_ch == 2) && n < 50) begin
            @(negedge ap_clk); n++;
        end
        chk("wrap_ch2_seen", 32'(n < 50), 1);
        chk("wrap_rr_mid", 32'(dut.rr_ptr), 1);
        drain("wrap_drain");
        chk("wrap_rr", 32'(dut.rr_ptr), 3);

        // enable drop during a ch2 burst
        put(2, 4'h1); put(2, 4'h2);
        exp_w(2, 0, 4'h1); exp_w(2, 1, 4'h2);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge ap_clk); n++; end
        chk("en_start", 32'(out_valid), 1);
        enable = 1'b0;
        put(3, 4'h3); put(1, 4'h4); put(2, 4'h5);
        exp_w(3, 0, 4'h3); exp_w(1, 0, 4'h4); exp_w(2, 0, 4'h5);
        repeat (3) @(negedge ap_clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            chk("en_off_read", 32'(ch_read), 0);
            chk("en_off_busy", 32'(busy), 0);
        end
        chk("en_off_pending", 32'(exp_q.size()), 3);
        enable = 1'b1;
        drain("en_drain");
        chk("en_rr", 32'(dut.rr_ptr), 3);

        // asynchronous reset mid-burst
        sb_on = 1'b0;
        put(2, 4'hD); put(2, 4'hE); put(2, 4'hF); put(2, 4'h1);
        n = 0;
        while (!(out_valid && ch_read[2]) && n < 50) begin
            @(negedge ap_clk); n++;
        end
        chk("mid_burst_seen", 32'(n < 50), 1);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_read", 32'(ch_read), 0);
        chk("arst_ch", 32'(out_ch), 0);
        chk("arst_last", 32'(out_last), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_data", 32'(out_data), 0);
        for (int k = 0; k < NUM_CH; k++) fq[k].delete();
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        sb_on = 1'b1;
        put(3, 4'h6); put(1, 4'h7);
        exp_w(1, 0, 4'h7); exp_w(3, 0, 4'h6);
        drain("post_rst_drain");
        chk("word_count", 32'(accepted), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_fifo_rr_arb.md
# pp_pipeline_accel_fifo_rr_arb

Round-robin read-side arbiter that merges NUM_CH shallow shift-register channel FIFOs into one output stream for the pre-processing pipeline. It drains the granted channel in bursts of up to BURST_LEN words through a one-deep registered output stage with valid/ready backpressure. Each output word is tagged with its source channel. The block sits between the per-channel `_fifo_w*_d*_S` instances and the single downstream consumer.

## Interface
- NUM_CH, 4, number of input channels (2..8)
- DATA_WIDTH, 4, word width
- CH_WIDTH, 2, channel index width, equal to clog2(NUM_CH)
- BURST_LEN, 2, maximum words per grant (1..15)
- CNT_WIDTH, 4, beat counter width, at least clog2(BURST_LEN+1)

- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- enable  in  1  permits new grants
- ch_empty_n  in  NUM_CH  per-channel FIFO not-empty
- ch_dout  in  NUM_CH*DATA_WIDTH  per-channel FIFO head word (first-word fall-through); channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- ch_read  out  NUM_CH  per-channel pop strobe; at most one bit is high
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH  output word
- out_ch  out  CH_WIDTH  source channel of out_data
- out_last  out  1  word completes a full BURST_LEN burst
- busy  out  1  state is GRANT, or out_valid is high

## Operation
- State machine states:
  - IDLE: arbitration. If enable is high and any ch_empty_n bit is set, choose the first set channel when searching from rr_ptr upward, modulo NUM_CH. Load gnt with that channel, clear beat_cnt, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: define slot_free = ~out_valid | out_ready.
    - ch_read[gnt] = ch_empty_n[gnt] & slot_free. This is combinational, and all other ch_read bits are 0.
    - On a pop:
      - out_data <= ch_dout[gnt]
      - out_ch <= gnt
      - out_valid <= 1
      - beat_cnt increments
      - out_last <= (beat_cnt+1 == BURST_LEN)
    - Leave GRANT for IDLE and set rr_ptr <= (gnt+1) mod NUM_CH when either of these holds:
      - a pop makes beat_cnt+1 == BURST_LEN, or
      - ch_empty_n[gnt] is 0 (early release; no pop occurs that cycle).
- Output register:
  - out_valid clears when out_ready is high and no new pop occurs.
  - Simultaneous accept and pop loads the new word with no bubble.
  - While out_valid is high and out_ready is low, out_data, out_ch and out_last hold, and ch_read is 0.
- enable low:
  - blocks the IDLE to GRANT transition only;
  - an in-progress grant completes normally;
  - the output register still drains.
- rr_ptr wraps from NUM_CH-1 to 0. It is updated only on leaving GRANT.
- A partial burst ended by early release never asserts out_last.
- Reset (asynchronous, any time including mid-burst):
  - state = IDLE, rr_ptr = 0, gnt = 0, beat_cnt = 0;
  - out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, busy = 0;
  - ch_read = 0 immediately, because it is gated by state.
  - No partial-burst state survives reset.

## Timing
- Arbitration costs one cycle: the IDLE cycle, with no pop.
- The first pop can occur in the first GRANT cycle.
- The popped word appears on out_data/out_valid at the next rising edge. Latency from ch_read to out_valid is 1 cycle.
- Sustained throughput with out_ready held at 1 and source channels never empty: BURST_LEN words per BURST_LEN+1 cycles.
- ch_read depends combinationally on ch_empty_n, out_valid and out_ready. It has no dependency on ch_dout.
- Early release costs one GRANT cycle with no pop, then one IDLE cycle.
- ch_empty_n is sampled only for the granted channel while in GRANT.

## Test plan
- Reset: assert ap_rst_n=0 mid-burst, with out_valid=1 and ch_read[2]=1 -> asynchronously, out_valid=0, ch_read=0, out_ch=0, out_last=0, busy=0; after release, the first grant goes to the lowest non-empty channel counting from 0.
- Single channel, NUM_CH=4, BURST_LEN=2: ch1 holds 3 words A,B,C; out_ready=1 -> out_data sequence is A, B (out_last=1), a one-cycle IDLE bubble, then C (out_last=0), then early release to IDLE; out_ch=1 throughout.
- Fairness: all 4 channels always non-empty, BURST_LEN=2 -> out_ch sequence 0,0,1,1,2,2,3,3,0,0; out_last high on every second word.
- Wrap: rr_ptr=3, only ch0 and ch2 non-empty -> ch0 is granted first, then ch2; rr_ptr becomes 1, then 3.
- Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data, out_ch and out_last are stable, ch_read=0, and no words are lost or duplicated; the scoreboard word count matches the count written into the FIFOs.
- Enable: drop enable during a ch2 burst -> the burst completes and the block stays in IDLE with ch_read=0; raising enable resumes arbitration with ch3 searched first.
